// File: rtl/dcm_lock_monitor.sv
// dcm_lock_monitor: supervises a DCM's LOCKED/STATUS from BUS_CLK, sequences DCM_RST and SYS_RST.
// Optional: define DCM_STATUS_CHECK_EN to treat STATUS[1] (CLKIN stopped) / STATUS[2] (CLKFX stopped) as loss.
module dcm_lock_monitor #(
  parameter int RST_PULSE_CYCLES = 4,
  parameter int LOCK_TIMEOUT     = 65536,
  parameter int HOLDOFF_CYCLES   = 1024,
  parameter int MAX_RETRIES      = 7
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST,
  input  logic        DCM_LOCKED,
  input  logic [7:0]  DCM_STATUS,
  input  logic        USER_RST,
  output logic        DCM_RST,
  output logic        SYS_RST,
  output logic        READY,
  output logic        FAIL,
  output logic [7:0]  RETRY_CNT,
  output logic [15:0] LOSS_CNT
);

  localparam int PULSE_W = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
  localparam int WAIT_W  = (LOCK_TIMEOUT > 1)     ? $clog2(LOCK_TIMEOUT)     : 1;
  localparam int HOLD_W  = (HOLDOFF_CYCLES > 1)   ? $clog2(HOLDOFF_CYCLES)   : 1;

  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(LOCK_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RESET_DCM,
    ST_WAIT_LOCK,
    ST_HOLDOFF,
    ST_RUN,
    ST_FAILED
  } state_e;

  // Synchronisers: DCM outputs are asynchronous to BUS_CLK
  logic lock_meta_q, lock_s_q;
  logic loss;

`ifdef DCM_STATUS_CHECK_EN
  logic [1:0] status_meta_q, status_s_q;
  logic       unused_status;

  assign unused_status = ^{DCM_STATUS[7:3], DCM_STATUS[0]};
  assign loss          = !lock_s_q || (|status_s_q);

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      status_meta_q <= '0;
      status_s_q    <= '0;
    end else begin
      status_meta_q <= DCM_STATUS[2:1];
      status_s_q    <= status_meta_q;
    end
  end
`else
  logic unused_status;

  assign unused_status = ^DCM_STATUS;
  assign loss          = !lock_s_q;
`endif

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so both stages sample their old values on the same edge.
      lock_meta_q <= DCM_LOCKED;
      lock_s_q    <= lock_meta_q;
    end
  end

  state_e              state_q, state_d;
  logic [PULSE_W-1:0]  pulse_cnt_q, pulse_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [7:0]          retry_cnt_q, retry_cnt_d;
  logic [15:0]         loss_cnt_q, loss_cnt_d;
  logic                dcm_rst_q, dcm_rst_d;
  logic                sys_rst_q, sys_rst_d;
  logic                ready_q, ready_d;
  logic                fail_q, fail_d;

  logic [7:0] retry_inc;
  logic       retry_exhausted;

  assign retry_inc       = (retry_cnt_q == 8'hFF) ? 8'hFF : retry_cnt_q + 8'd1;
  assign retry_exhausted = (MAX_RETRIES != 0) && (int'(retry_inc) >= MAX_RETRIES);

  always_comb begin
    // NOTE: every target gets a default first so no path can leave a latch behind.
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    retry_cnt_d = retry_cnt_q;
    loss_cnt_d  = loss_cnt_q;

    if (USER_RST) begin
      state_d     = ST_RESET_DCM;
      retry_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_RESET_DCM: begin
          if (pulse_cnt_q == PULSE_LAST) state_d = ST_WAIT_LOCK;
          else                           pulse_cnt_d = pulse_cnt_q + 1'b1;
        end
        ST_WAIT_LOCK: begin
          // Lock takes priority over a timeout landing on the same cycle
          if (lock_s_q) begin
            state_d = ST_HOLDOFF;
          end else if (wait_cnt_q == WAIT_LAST) begin
            retry_cnt_d = retry_inc;
            state_d     = retry_exhausted ? ST_FAILED : ST_RESET_DCM;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (loss) begin
            retry_cnt_d = retry_inc;
            state_d     = retry_exhausted ? ST_FAILED : ST_RESET_DCM;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_d     = ST_RUN;
            retry_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (loss) begin
            state_d    = ST_RESET_DCM;
            loss_cnt_d = (loss_cnt_q == 16'hFFFF) ? 16'hFFFF : loss_cnt_q + 16'd1;
          end
        end
        ST_FAILED: ;
        default: state_d = ST_RESET_DCM;
      endcase
    end

    // Every state entry (including a USER_RST restart) starts all timers from zero
    if (USER_RST || (state_d != state_q)) begin
      pulse_cnt_d = '0;
      wait_cnt_d  = '0;
      hold_cnt_d  = '0;
    end

    dcm_rst_d = (state_d == ST_RESET_DCM);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fail_d    = (state_d == ST_FAILED);
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      // NOTE: every register, counters included, has a defined reset value; nothing relies on power-up state.
      state_q     <= ST_RESET_DCM;
      pulse_cnt_q <= '0;
      wait_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      retry_cnt_q <= '0;
      loss_cnt_q  <= '0;
      dcm_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
      dcm_rst_q   <= dcm_rst_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign DCM_RST   = dcm_rst_q;
  assign SYS_RST   = sys_rst_q;
  assign READY     = ready_q;
  assign FAIL      = fail_q;
  assign RETRY_CNT = retry_cnt_q;
  assign LOSS_CNT  = loss_cnt_q;

endmodule
